// File: rtl/flit_injector_pkg.sv
// Shared link-word definitions for the BLESS ring. The priority comparator,
// the router and the injector all decode the same control word layout.
package flit_injector_pkg;

  // Field widths of the link control word and payload.
  localparam int AGE_W     = 8;
  localparam int SRC_W     = 4;
  localparam int DEST_W    = 4;
  localparam int DATA_W    = 16;
  localparam int SPARE_W   = 3;
  localparam int CONTROL_W = SPARE_W + DEST_W + SRC_W + AGE_W + 1;

  // Field positions inside the control word (LSB first).
  localparam int VALID_F   = 0;
  localparam int AGE_LSB   = 1;
  localparam int SRC_LSB   = AGE_LSB + AGE_W;
  localparam int DEST_LSB  = SRC_LSB + SRC_W;
  localparam int SPARE_LSB = DEST_LSB + DEST_W;

  // Ages stop counting here instead of wrapping back to a "young" value.
  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  // Control word as seen on the link; member order matches the field positions.
  typedef struct packed {
    logic [SPARE_W-1:0] spare;
    logic [DEST_W-1:0]  dest;
    logic [SRC_W-1:0]   src;
    logic [AGE_W-1:0]   age;
    logic               valid;
  } ctrl_t;

  // What the output stage loads at the next edge.
  typedef enum logic [1:0] {
    SLOT_IDLE    = 2'd0,
    SLOT_TRANSIT = 2'd1,
    SLOT_INJECT  = 2'd2
  } slot_sel_e;

  // Saturating one-step age increment.
  function automatic logic [AGE_W-1:0] age_sat_inc(input logic [AGE_W-1:0] age);
    return (age == AGE_MAX) ? AGE_MAX : age + 1'b1;
  endfunction

endpackage

// File: rtl/flit_injector_inj_queue.sv
// Injection queue: circular buffer of {dest, data, wait_age}. Every waiting
// entry ages by one (saturating) per cycle so a starved flit enters the ring
// with a high priority.
module inj_queue
  import flit_injector_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DEST_W-1:0] push_dest,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DEST_W-1:0] head_dest,
  output logic [DATA_W-1:0] head_data,
  output logic [AGE_W-1:0]  head_age,
  output logic [CNT_W-1:0]  count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [CNT_W-1:0]  count_next;
  logic              push_ok;
  logic              pop_ok;

  logic [DEST_W-1:0] dest_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [AGE_W-1:0]  age_reg  [DEPTH];
  logic [AGE_W-1:0]  age_next [DEPTH];

  // Guard against misuse: never overrun a full buffer or underrun an empty one.
  assign push_ok = push && (count_reg < CNT_W'(DEPTH));
  assign pop_ok  = pop && (count_reg != '0);

  // Occupancy follows push/pop; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_next = count_reg;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
    end
  end

  // Payload storage needs no reset: only entries inside the occupancy window are read.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      dest_mem[wr_ptr_reg] <= push_dest;
      data_mem[wr_ptr_reg] <= push_data;
    end
  end

  // Per-entry wait-age update: a fresh push starts at 0, a waiting entry ages.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
      logic [PTR_W-1:0] offset;
      logic             occupied;
      logic             popped;
      logic             pushed;

      assign offset   = PTR_W'(gi) - rd_ptr_reg;
      assign occupied = CNT_W'(offset) < count_reg;
      assign popped   = pop_ok && (rd_ptr_reg == PTR_W'(gi));
      assign pushed   = push_ok && (wr_ptr_reg == PTR_W'(gi));
      assign age_next[gi] = pushed                 ? '0 :
                            (occupied && !popped)  ? age_sat_inc(age_reg[gi]) :
                                                     age_reg[gi];
    end
  endgenerate

  // Wait-age registers, kept resettable so a discarded queue holds no stale age.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) age_reg[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) age_reg[i] <= age_next[i];
    end
  end

  assign head_dest = dest_mem[rd_ptr_reg];
  assign head_data = data_mem[rd_ptr_reg];
  assign head_age  = age_reg[rd_ptr_reg];
  assign count     = count_reg;

endmodule

// File: rtl/flit_injector.sv
// Local injection point of a bufferless ring node. A queued local flit takes
// an empty link slot; otherwise the transit flit passes through one hop older.
// All link outputs are registered.
module flit_injector
  import flit_injector_pkg::*;
#(
  parameter int NODE_ID = 0,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inj_valid,
  output logic                 inj_ready,
  input  logic [DEST_W-1:0]    inj_dest,
  input  logic [DATA_W-1:0]    inj_data,
  input  logic [CONTROL_W-1:0] link_ctrl_in,
  input  logic [DATA_W-1:0]    link_data_in,
  output logic [CONTROL_W-1:0] link_ctrl_out,
  output logic [DATA_W-1:0]    link_data_out,
  output logic                 inject_fire,
  output logic [CNT_W-1:0]     fifo_count
);

  ctrl_t             link_ctrl;
  ctrl_t             ctrl_next;
  ctrl_t             ctrl_out_reg;
  logic [DATA_W-1:0] data_next;
  logic [DATA_W-1:0] data_out_reg;
  logic              fire_next;
  logic              fire_reg;
  slot_sel_e         slot_sel;

  logic              slot_free;
  logic              queue_nonempty;
  logic              do_push;
  logic              do_inject;
  logic [CNT_W-1:0]  count;
  logic [DEST_W-1:0] head_dest;
  logic [DATA_W-1:0] head_data;
  logic [AGE_W-1:0]  head_age;

  assign link_ctrl      = ctrl_t'(link_ctrl_in);
  assign slot_free      = ~link_ctrl.valid;
  assign queue_nonempty = (count != '0);
  // Ready comes only from the registered count, so a pop never raises it early.
  assign inj_ready      = (count < CNT_W'(DEPTH));
  assign do_push        = inj_valid && inj_ready;
  assign do_inject      = slot_free && queue_nonempty;

  inj_queue #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (do_push),
    .push_dest (inj_dest),
    .push_data (inj_data),
    .pop       (do_inject),
    .head_dest (head_dest),
    .head_data (head_data),
    .head_age  (head_age),
    .count     (count)
  );

  // Slot decision: a valid transit flit always wins; an empty slot takes the queue head.
  always_comb begin
    slot_sel = SLOT_IDLE;
    if (!slot_free) begin
      slot_sel = SLOT_TRANSIT;
    end else if (queue_nonempty) begin
      slot_sel = SLOT_INJECT;
    end
  end

  // Build the next output word for the chosen slot content.
  always_comb begin
    ctrl_next = '0;
    data_next = '0;
    fire_next = 1'b0;
    case (slot_sel)
      SLOT_TRANSIT: begin
        ctrl_next     = link_ctrl;
        ctrl_next.age = age_sat_inc(link_ctrl.age);
        data_next     = link_data_in;
      end
      SLOT_INJECT: begin
        ctrl_next.valid = 1'b1;
        ctrl_next.age   = head_age;
        ctrl_next.src   = SRC_W'(NODE_ID);
        ctrl_next.dest  = head_dest;
        data_next       = head_data;
        fire_next       = 1'b1;
      end
      default: begin
        ctrl_next = '0;
        data_next = '0;
        fire_next = 1'b0;
      end
    endcase
  end

  // Registered output stage towards the router input port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_out_reg <= '0;
      data_out_reg <= '0;
      fire_reg     <= 1'b0;
    end else begin
      ctrl_out_reg <= ctrl_next;
      data_out_reg <= data_next;
      fire_reg     <= fire_next;
    end
  end

  assign link_ctrl_out = ctrl_out_reg;
  assign link_data_out = data_out_reg;
  assign inject_fire   = fire_reg;
  assign fifo_count    = count;

endmodule

// File: tb/tb_flit_injector.sv
// Directed bench for flit_injector: a vector table of per-cycle inputs and
// hand-computed expected outputs, plus sequences for saturation and async reset.
module tb_flit_injector;
  import flit_injector_pkg::*;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 inj_valid = 1'b0;
  logic                 inj_ready;
  logic [DEST_W-1:0]    inj_dest = '0;
  logic [DATA_W-1:0]    inj_data = '0;
  logic [CONTROL_W-1:0] link_ctrl_in = '0;
  logic [DATA_W-1:0]    link_data_in = '0;
  logic [CONTROL_W-1:0] link_ctrl_out;
  logic [DATA_W-1:0]    link_data_out;
  logic                 inject_fire;
  logic [2:0]           fifo_count;

  flit_injector #(
    .NODE_ID (3),
    .DEPTH   (4),
    .CNT_W   (3)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .inj_valid     (inj_valid),
    .inj_ready     (inj_ready),
    .inj_dest      (inj_dest),
    .inj_data      (inj_data),
    .link_ctrl_in  (link_ctrl_in),
    .link_data_in  (link_data_in),
    .link_ctrl_out (link_ctrl_out),
    .link_data_out (link_data_out),
    .inject_fire   (inject_fire),
    .fifo_count    (fifo_count)
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [CONTROL_W-1:0] cw(input logic v, input logic [7:0] age,
                                              input logic [3:0] src, input logic [3:0] dest);
    ctrl_t c;
    c       = '0;
    c.valid = v;
    c.age   = age;
    c.src   = src;
    c.dest  = dest;
    return c;
  endfunction

  typedef struct {
    logic                 iv;
    logic [3:0]           idest;
    logic [15:0]          idata;
    logic [CONTROL_W-1:0] lctrl;
    logic [15:0]          ldata;
    logic [CONTROL_W-1:0] ectrl;
    logic [15:0]          edata;
    logic                 efire;
    logic [2:0]           ecnt;
    logic                 erdy;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic iv, input logic [3:0] idest, input logic [15:0] idata,
                              input logic [CONTROL_W-1:0] lctrl, input logic [15:0] ldata,
                              input logic [CONTROL_W-1:0] ectrl, input logic [15:0] edata,
                              input logic efire, input logic [2:0] ecnt, input logic erdy);
    vec_t v;
    v.iv = iv; v.idest = idest; v.idata = idata; v.lctrl = lctrl; v.ldata = ldata;
    v.ectrl = ectrl; v.edata = edata; v.efire = efire; v.ecnt = ecnt; v.erdy = erdy;
    vecs.push_back(v);
  endfunction

  task automatic check_outputs(input string tag, input logic [CONTROL_W-1:0] ectrl,
                               input logic [15:0] edata, input logic efire,
                               input logic [2:0] ecnt, input logic erdy);
    check({tag, ".ctrl"},  32'(link_ctrl_out), 32'(ectrl));
    check({tag, ".data"},  32'(link_data_out), 32'(edata));
    check({tag, ".fire"},  32'(inject_fire),   32'(efire));
    check({tag, ".count"}, 32'(fifo_count),    32'(ecnt));
    check({tag, ".ready"}, 32'(inj_ready),     32'(erdy));
  endtask

  initial begin
    // ---------------- vector table (NODE_ID = 3) ----------------
    add(0, 0, 16'h0000, '0, 16'h0000, '0, 16'h0000, 0, 0, 1);                                 // idle
    add(0, 0, 16'h0000, cw(0, 8'h3C, 4'h5, 4'h6), 16'hDEAD, '0, 16'h0000, 0, 0, 1);           // invalid slot ignored
    add(1, 5, 16'h00AB, '0, 16'h0000, '0, 16'h0000, 0, 1, 1);                                 // push, no bypass
    add(0, 0, 16'h0000, '0, 16'h0000, cw(1, 8'd0, 4'd3, 4'd5), 16'h00AB, 1, 0, 1);            // inject age 0
    add(0, 0, 16'h0000, '0, 16'h0000, '0, 16'h0000, 0, 0, 1);                                 // empty again
    add(0, 0, 16'h0000, cw(1, 8'd7, 4'd2, 4'd9), 16'h1234, cw(1, 8'd8, 4'd2, 4'd9), 16'h1234, 0, 0, 1);
    add(1, 1, 16'h0011, cw(1, 8'd10, 4'd1, 4'd2), 16'h5555, cw(1, 8'd11, 4'd1, 4'd2), 16'h5555, 0, 1, 1);
    for (int k = 0; k < 3; k++)
      add(0, 0, 16'h0000, cw(1, 8'd10, 4'd1, 4'd2), 16'h5555, cw(1, 8'd11, 4'd1, 4'd2), 16'h5555, 0, 1, 1);
    add(0, 0, 16'h0000, '0, 16'h0000, cw(1, 8'd3, 4'd3, 4'd1), 16'h0011, 1, 0, 1);            // waited 3 cycles
    add(0, 0, 16'h0000, cw(1, 8'd255, 4'd4, 4'd4), 16'hFFFF, cw(1, 8'd255, 4'd4, 4'd4), 16'hFFFF, 0, 0, 1);
    add(0, 0, 16'h0000, cw(1, 8'd254, 4'd0, 4'd7), 16'h0F0F, cw(1, 8'd255, 4'd0, 4'd7), 16'h0F0F, 0, 0, 1);
    add(1, 7, 16'h0077, '0, 16'h0000, '0, 16'h0000, 0, 1, 1);
    add(1, 8, 16'h0088, '0, 16'h0000, cw(1, 8'd0, 4'd3, 4'd7), 16'h0077, 1, 1, 1);            // push+pop
    add(0, 0, 16'h0000, '0, 16'h0000, cw(1, 8'd0, 4'd3, 4'd8), 16'h0088, 1, 0, 1);
    for (int k = 0; k < 4; k++)
      add(1, 4'(k + 1), 16'(16'h00A1 + k), cw(1, 8'd0, 4'd0, 4'd0), 16'h0000,
          cw(1, 8'd1, 4'd0, 4'd0), 16'h0000, 0, 3'(k + 1), (k < 3));                          // fill while busy
    add(1, 9, 16'h00A9, cw(1, 8'd0, 4'd0, 4'd0), 16'h0000, cw(1, 8'd1, 4'd0, 4'd0), 16'h0000, 0, 4, 0); // full
    add(1, 9, 16'h00A9, '0, 16'h0000, cw(1, 8'd4, 4'd3, 4'd1), 16'h00A1, 1, 3, 1);            // offer not taken
    add(0, 0, 16'h0000, '0, 16'h0000, cw(1, 8'd4, 4'd3, 4'd2), 16'h00A2, 1, 2, 1);
    add(0, 0, 16'h0000, '0, 16'h0000, cw(1, 8'd4, 4'd3, 4'd3), 16'h00A3, 1, 1, 1);
    add(0, 0, 16'h0000, '0, 16'h0000, cw(1, 8'd4, 4'd3, 4'd4), 16'h00A4, 1, 0, 1);
    add(0, 0, 16'h0000, '0, 16'h0000, '0, 16'h0000, 0, 0, 1);

    // ---------------- reset state ----------------
    #12;
    check_outputs("reset", '0, 16'h0000, 0, 0, 1);
    @(negedge clk);
    reset = 1'b0;

    // ---------------- table ----------------
    foreach (vecs[i]) begin
      inj_valid    = vecs[i].iv;
      inj_dest     = vecs[i].idest;
      inj_data     = vecs[i].idata;
      link_ctrl_in = vecs[i].lctrl;
      link_data_in = vecs[i].ldata;
      @(posedge clk);
      #1;
      $display("vec %0d: in v=%0b d=%0h ctrl=%h | out ctrl=%h data=%h fire=%0b cnt=%0d rdy=%0b",
               i, vecs[i].iv, vecs[i].idest, vecs[i].lctrl, link_ctrl_out, link_data_out,
               inject_fire, fifo_count, inj_ready);
      check_outputs($sformatf("vec%0d", i), vecs[i].ectrl, vecs[i].edata, vecs[i].efire,
                    vecs[i].ecnt, vecs[i].erdy);
    end

    // ---------------- wait-age saturation ----------------
    inj_valid    = 1'b1;
    inj_dest     = 4'd2;
    inj_data     = 16'hBEEF;
    link_ctrl_in = cw(1, 8'd10, 4'd1, 4'd2);
    link_data_in = 16'h4444;
    @(posedge clk);
    #1;
    inj_valid = 1'b0;
    check("sat.count", 32'(fifo_count), 32'd1);
    repeat (300) begin
      @(posedge clk);
      #1;
    end
    check("sat.transit", 32'(link_ctrl_out), 32'(cw(1, 8'd11, 4'd1, 4'd2)));
    link_ctrl_in = '0;
    link_data_in = '0;
    @(posedge clk);
    #1;
    $display("sat: out ctrl=%h data=%h fire=%0b", link_ctrl_out, link_data_out, inject_fire);
    check_outputs("sat.inject", cw(1, 8'd255, 4'd3, 4'd2), 16'hBEEF, 1, 0, 1);

    // ---------------- asynchronous reset mid-operation ----------------
    link_ctrl_in = cw(1, 8'd20, 4'd1, 4'd1);
    link_data_in = 16'h2222;
    inj_valid    = 1'b1;
    inj_dest     = 4'd6;
    inj_data     = 16'h0066;
    @(posedge clk);
    #1;
    inj_dest = 4'd7;
    inj_data = 16'h0077;
    @(posedge clk);
    #1;
    inj_valid = 1'b0;
    check_outputs("prerst", cw(1, 8'd21, 4'd1, 4'd1), 16'h2222, 0, 2, 1);
    #2;
    reset = 1'b1;
    #1;
    $display("rst: out ctrl=%h data=%h fire=%0b cnt=%0d", link_ctrl_out, link_data_out,
             inject_fire, fifo_count);
    check_outputs("rst.async", '0, 16'h0000, 0, 0, 1);
    @(negedge clk);
    reset        = 1'b0;
    link_ctrl_in = '0;
    link_data_in = '0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      check_outputs($sformatf("postrst%0d", c), '0, 16'h0000, 0, 0, 1);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/flit_injector.md
Name: flit_injector

Overview:
- Local-node injection point for the age-based bufferless (BLESS) ring/router: it produces the control words that the age/source priority logic later consumes.
- Queues flits from the local core and stamps each with valid, age, src and dest.
- Injects a flit only into an empty link slot (valid=0); otherwise it forwards the transit flit with its age incremented by one hop.
- Registered output stage sits between the upstream link and the router input port.

Parameters:
- NODE_ID, 0, value written to `src_f of every injected flit (width `src_w).
- DEPTH, 4, injection queue entries; power of 2, minimum 2.
- CNT_W, 3, width of fifo_count; equals log2(DEPTH)+1.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-high reset.
- inj_valid  in  1  core offers a flit.
- inj_ready  out  1  queue can accept a flit.
- inj_dest  in  `dest_w  destination node of the offered flit.
- inj_data  in  `data_w  payload of the offered flit.
- link_ctrl_in  in  `control_w  upstream slot control word.
- link_data_in  in  `data_w  upstream slot payload.
- link_ctrl_out  out  `control_w  registered control word to the router input.
- link_data_out  out  `data_w  registered payload to the router input.
- inject_fire  out  1  registered pulse: this cycle's output slot holds a newly injected flit.
- fifo_count  out  CNT_W  current queue occupancy.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: queue pointers 0, count 0, link_ctrl_out 0, link_data_out 0, inject_fire 0. inj_ready is 1 once reset is low.
- Reset mid-operation discards all queued flits; nothing is injected afterwards until a new push.
- inj_ready = (count < DEPTH), driven only from the registered count. There is no full-and-pop bypass: a pop does not raise ready in the same cycle.
- Push: occurs when inj_valid && inj_ready at a clk edge. The flit is written at the tail with wait_age 0. Pointers wrap modulo DEPTH.
- Wait aging: at every edge, each occupied entry that is not popped does wait_age = sat(wait_age+1).
- Saturation: AGE_MAX is all ones of `age_w; sat(x) = min(x, AGE_MAX).
- Slot free: free = ~link_ctrl_in[`valid_f]. Inject happens at an edge when free && count>0. The head entry is popped.
- Inject output (registered, 1-cycle latency):
  - valid = 1, age = head wait_age (pre-increment value), src = NODE_ID, dest = head dest.
  - all other control bits 0; link_data_out = head data; inject_fire = 1.
- Transit (link valid): link_ctrl_out = link_ctrl_in with `age_f replaced by sat(age+1); link_data_out = link_data_in; inject_fire = 0.
- Empty slot with empty queue: link_ctrl_out = 0, link_data_out = 0, inject_fire = 0.
- No bypass from input to link: a flit pushed at edge t can be injected at edge t+1 at the earliest, and is then injected with age 0.
- Simultaneous push and pop: count unchanged; both pointers advance.
- Push into a full queue cannot occur because inj_ready is 0.
- Ordering: strict FIFO; no reordering.

Decomposition:
- defines.v: `control_w, `age_w, `src_w, `dest_w, `data_w, field selects `valid_f/`age_f/`src_f/`dest_f, AGE_MAX constant. These are shared with the priority comparator and router.
- Sub-module inj_queue: circular buffer storing {dest, data, wait_age}.
  - Interface: push/pop, head outputs, count.
  - Implements per-entry saturating wait-age increment.
- flit_injector top holds the slot-free decision, the transit age increment and the output registers.

Test Plan:
- Reset, then idle (link invalid, no pushes) → outputs all 0, inj_ready=1, fifo_count=0 every cycle.
- NODE_ID=3; push dest=5 data=0xAB at edge t; link free → after edge t+1: link_ctrl_out valid=1, age=0, src=3, dest=5; link_data_out=0xAB; inject_fire=1; fifo_count=0.
- Flit queued, link valid with age 10 for 3 cycles, then free:
  - blocked cycles output ages 11,11,11 (one per transit flit) with inject_fire=0;
  - injected flit carries age=3.
- Link busy, 4 pushes → inj_ready=0 after the 4th; a 5th offer is not accepted. Link frees → fifo_count=3, and inj_ready=1 the following cycle.
- Saturation, AGE_MAX=255:
  - transit flit with age 255 → output age 255;
  - flit blocked 300 cycles → injected age 255.
- 2 flits queued, reset asserted asynchronously mid-cycle → outputs 0 and count 0 immediately; after release with link free, no injection occurs.
